// File: rtl/dmem_port.sv
// Data-memory responder: zero-wait internal byte-writable RAM for the low window,
// req/ack external bus with timeout for every other address.
module dmem_port #(
  parameter int RAM_AW  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_r,
  input  logic        data_w,
  input  logic [1:0]  data_sz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_busy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [3:0]  ext_be,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_we_q, ext_we_d;
  logic [3:0]        ext_be_q, ext_be_d;
  logic [31:0]       ext_addr_q, ext_addr_d;
  logic [31:0]       ext_wdata_q, ext_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       ext_lat_q, ext_lat_d;
  logic              sel_int_q, sel_int_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [31:0]       mem_q [0:(1 << RAM_AW) - 1];
  logic [31:0]       ram_rdata_q;

  logic              acc_s, int_s, ram_we_s, ram_re_s, ext_go_s;
  logic [3:0]        mask_s, be_s;
  logic [31:0]       wdata_sh_s;
  logic [RAM_AW-1:0] widx_s;

  // Reset suppresses acceptance so the RAM is not disturbed while rst is held.
  assign acc_s      = (data_r | data_w) & ~busy_q & ~rst;
  assign int_s      = (data_addr[31:RAM_AW+2] == {(30 - RAM_AW){1'b0}});
  assign widx_s     = data_addr[RAM_AW+1:2];
  assign ram_we_s   = acc_s & int_s & data_w;
  assign ram_re_s   = acc_s & int_s & ~data_w;
  assign ext_go_s   = acc_s & ~int_s;
  assign be_s       = mask_s << data_addr[1:0];
  assign wdata_sh_s = data_wdata << {data_addr[1:0], 3'b000};

  always_comb begin
    case (data_sz)
      2'd0:    mask_s = 4'b0001;
      2'd1:    mask_s = 4'b0011;
      default: mask_s = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_be_d    = ext_be_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    bus_err_d   = 1'b0;
    ext_lat_d   = ext_lat_q;
    sel_int_d   = sel_int_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (ext_go_s) begin
          state_d     = S_WAIT;
          busy_d      = 1'b1;
          ext_req_d   = 1'b1;
          ext_we_d    = data_w;
          ext_be_d    = be_s;
          ext_addr_d  = {data_addr[31:2], 2'b00};
          ext_wdata_d = wdata_sh_s;
          cnt_d       = {CW{1'b0}};
        end else begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          ext_req_d = 1'b0;
        end
        if (ram_re_s) begin
          sel_int_d = 1'b1;
        end else begin
          sel_int_d = sel_int_q;
        end
      end
      S_WAIT: begin
        if (ext_ack || (cnt_q == CW'(TIMEOUT))) begin
          state_d   = S_RESP;
          busy_d    = 1'b0;
          ext_req_d = 1'b0;
          bus_err_d = ~ext_ack;
          // Writes complete without touching the read-data path.
          if (!ext_we_q) begin
            ext_lat_d = ext_ack ? ext_rdata : 32'hFFFF_FFFF;
            sel_int_d = 1'b0;
          end else begin
            ext_lat_d = ext_lat_q;
            sel_int_d = sel_int_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        ext_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_be_q    <= 4'b0000;
      ext_addr_q  <= 32'h0000_0000;
      ext_wdata_q <= 32'h0000_0000;
      bus_err_q   <= 1'b0;
      ext_lat_q   <= 32'h0000_0000;
      sel_int_q   <= 1'b0;
      cnt_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_be_q    <= ext_be_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      bus_err_q   <= bus_err_d;
      ext_lat_q   <= ext_lat_d;
      sel_int_q   <= sel_int_d;
      cnt_q       <= cnt_d;
    end
  end

  // Byte-lane write and registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && be_s[i]) begin
        mem_q[widx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
      end
    end
    if (ram_re_s) begin
      ram_rdata_q <= mem_q[widx_s];
    end
  end

  assign data_rdata = sel_int_q ? ram_rdata_q : ext_lat_q;
  assign data_busy  = busy_q;
  assign ext_req    = ext_req_q;
  assign ext_we     = ext_we_q;
  assign ext_be     = ext_be_q;
  assign ext_addr   = ext_addr_q;
  assign ext_wdata  = ext_wdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed cases plus randomized traffic
// checked against a byte-level reference model of RAM and external bus.
module tb_dmem_port;

  localparam int RAM_AW  = 14;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_r = 1'b0;
  logic        data_w = 1'b0;
  logic [1:0]  data_sz = 2'd0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        data_busy;
  logic        ext_req;
  logic        ext_we;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata = 32'h0;
  logic        ext_ack = 1'b0;
  logic        bus_err;

  dmem_port #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .data_r(data_r), .data_w(data_w), .data_sz(data_sz),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_busy(data_busy),
    .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] pool [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Reference lane rules: byte lane i carries source byte (i - offset).
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) begin
      int j = i - int'(off);
      if (j >= 0 && j < nbytes(sz)) r[8*i +: 8] = wd[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] r = 4'h0;
    for (int i = 0; i < 4; i++) begin
      int j = i - int'(off);
      r[i] = (j >= 0 && j < nbytes(sz));
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_wsh(input logic [31:0] wd, input logic [1:0] off);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      int j = i - int'(off);
      if (j >= 0) r[8*i +: 8] = wd[8*j +: 8];
    end
    return r;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) & ((32'd1 << RAM_AW) - 32'd1);
  endfunction

  task automatic int_access(input logic we, input logic both, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd);
    data_w = we; data_r = ~we | both; data_sz = sz; data_addr = addr; data_wdata = wd;
    tick();
    data_r = 1'b0; data_w = 1'b0;
    if (we) begin
      ref_mem[widx(addr)] = merge(ref_mem.exists(widx(addr)) ? ref_mem[widx(addr)] : 32'h0,
                                  wd, sz, addr[1:0]);
    end else begin
      exp_rdata = ref_mem[widx(addr)];
    end
    check("int_busy", 32'(data_busy), 32'd0);
    check("int_ext_req", 32'(ext_req), 32'd0);
    check("int_bus_err", 32'(bus_err), 32'd0);
    check("int_rdata", data_rdata, exp_rdata);
  endtask

  // d = cycle (after the request cycle) in which ack is driven; 0 or > TIMEOUT+1 means never.
  task automatic ext_access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input int d, input logic [31:0] rdat);
    bit done = 1'b0;
    bit terr = 1'b0;
    data_w = we; data_r = ~we; data_sz = sz; data_addr = addr; data_wdata = wd;
    tick();
    data_r = 1'b0; data_w = 1'b0;
    for (int c = 1; c <= TIMEOUT + 1 && !done; c++) begin
      check("wait_req", 32'(ext_req), 32'd1);
      check("wait_busy", 32'(data_busy), 32'd1);
      check("wait_bus_err", 32'(bus_err), 32'd0);
      check("ext_addr", ext_addr, {addr[31:2], 2'b00});
      check("ext_we", 32'(ext_we), 32'(we));
      check("ext_be", 32'(ext_be), 32'(ref_be(sz, addr[1:0])));
      check("ext_wdata", ext_wdata, ref_wsh(wd, addr[1:0]));
      // Junk writes into the RAM pool while busy; they must be ignored.
      data_w = 1'($urandom_range(0, 1));
      data_sz = 2'($urandom_range(0, 3));
      data_addr = pool[$urandom_range(0, 15)];
      data_wdata = $urandom;
      ext_rdata = $urandom;
      if (c == d) begin
        ext_ack = 1'b1; ext_rdata = rdat; done = 1'b1;
      end else if (c == TIMEOUT + 1) begin
        done = 1'b1; terr = 1'b1;
      end
      tick();
    end
    ext_ack = 1'b0; data_w = 1'b0; data_r = 1'b0;
    if (!we) exp_rdata = terr ? 32'hFFFF_FFFF : rdat;
    check("resp_busy", 32'(data_busy), 32'd0);
    check("resp_req", 32'(ext_req), 32'd0);
    check("resp_bus_err", 32'(bus_err), 32'(terr));
    check("resp_rdata", data_rdata, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 15; i++) pool[i] = i * 32'h0000_0404;
    pool[15] = 32'h0000_FFFC;

    tick(); tick();
    check("rst_busy", 32'(data_busy), 32'd0);
    check("rst_req", 32'(ext_req), 32'd0);
    check("rst_we", 32'(ext_we), 32'd0);
    check("rst_be", 32'(ext_be), 32'd0);
    check("rst_addr", ext_addr, 32'd0);
    check("rst_wdata", ext_wdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    rst = 1'b0;

    int_access(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF);
    int_access(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    check("word_wr_rd", data_rdata, 32'hDEAD_BEEF);
    int_access(1'b1, 1'b0, 2'd0, 32'h0000_0103, 32'h0000_00AA);
    int_access(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    int_access(1'b1, 1'b0, 2'd1, 32'h0000_0103, 32'h0000_1234);
    int_access(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    check("half_drop", data_rdata, 32'h34AD_BEEF);

    for (int i = 0; i < 16; i++) int_access(1'b1, 1'b0, 2'd3, pool[i], $urandom);

    ext_access(1'b0, 2'd2, 32'h8000_0004, 32'h0, 3, 32'h0102_0304);
    int_access(1'b0, 1'b0, 2'd2, pool[3], 32'h0);
    ext_access(1'b0, 2'd2, 32'h8000_0008, 32'h0, 0, 32'h0);
    ext_access(1'b1, 2'd1, 32'h0001_0002, 32'h5566_7788, 5, 32'h0);
    ext_access(1'b0, 2'd0, 32'h0001_0001, 32'h0, 1, 32'hCAFE_F00D);
    for (int i = 0; i < 16; i++) int_access(1'b0, 1'b0, 2'd2, pool[i], 32'h0);

    // Reset in the middle of a wait aborts the access silently.
    data_r = 1'b1; data_addr = 32'h9000_0000;
    tick();
    data_r = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_req", 32'(ext_req), 32'd0);
      check("rstw_busy", 32'(data_busy), 32'd0);
      check("rstw_bus_err", 32'(bus_err), 32'd0);
      check("rstw_rdata", data_rdata, 32'd0);
      ext_ack = 1'b1; ext_rdata = $urandom;
      tick();
    end
    ext_ack = 1'b0;

    for (int t = 0; t < 200; t++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [31:0] wd = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        int_access(we, 1'($urandom_range(0, 1)), sz,
                   pool[$urandom_range(0, 15)] + 32'($urandom_range(0, 3)), wd);
      end else begin
        ext_access(we, sz, {1'b1, 31'($urandom)}, wd, $urandom_range(1, 6), $urandom);
      end
    end
    for (int i = 0; i < 16; i++) int_access(1'b0, 1'b0, 2'd2, pool[i], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
